// File: rtl/uart_probe_sampler_if.sv
// ---------------------------------------------------------------------------
// uart_probe_sampler_if
//   Playback port of the probe sampler: a request/valid stream that carries
//   captured samples, oldest first, to fabric logic.
//
//   Signals
//     rd_req    consumer -> sampler  request the next playback sample
//     rd_data   sampler -> consumer  playback sample (zero when not valid)
//     rd_valid  sampler -> consumer  rd_data valid this cycle
//     rd_last   sampler -> consumer  with rd_valid: last sample of capture
//
//   Modports
//     master  the consumer (UART dump, register read)
//     slave   the sampler
// ---------------------------------------------------------------------------
interface uart_probe_sampler_if #(
  parameter int PROBE_W = 16
);
  logic               rd_req;
  logic [PROBE_W-1:0] rd_data;
  logic               rd_valid;
  logic               rd_last;

  modport master (output rd_req, input rd_data, rd_valid, rd_last);
  modport slave  (input rd_req, output rd_data, rd_valid, rd_last);
endinterface

// File: rtl/uart_probe_sampler.sv
// ---------------------------------------------------------------------------
// uart_probe_sampler
//   Lightweight capture block for uart_reader debug signals. Records the
//   probe vector into a circular buffer, keeps PRE_TRIG samples of history,
//   triggers on a masked pattern match or an external trigger, stores the
//   post-trigger window and then plays the whole DEPTH-sample capture back
//   oldest-first over the rd port.
//
//   Parameters
//     PROBE_W   width of the probe vector / stored samples
//     DEPTH     buffer depth in samples (power of 2, >= 4)
//     PRE_TRIG  samples kept before the trigger sample (0 .. DEPTH-1)
//
//   Ports
//     clk         single clock
//     rst         asynchronous reset, active high
//     probe       signals sampled every clk
//     arm         one-cycle pulse: start or restart a capture
//     trig_mask   bits taking part in the pattern compare
//     trig_value  pattern compared under trig_mask
//     trig_ext    external trigger, level sampled each cycle
//     rd          playback port (slave side of uart_probe_sampler_if)
//     state       0 IDLE, 1 FILL, 2 ARMED, 3 POST, 4 DONE
//     triggered   trigger seen in the current capture
//     done        capture complete, buffer readable
// ---------------------------------------------------------------------------
module uart_probe_sampler #(
  parameter int PROBE_W  = 16,
  parameter int DEPTH    = 64,
  parameter int PRE_TRIG = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PROBE_W-1:0]  probe,
  input  logic                arm,
  input  logic [PROBE_W-1:0]  trig_mask,
  input  logic [PROBE_W-1:0]  trig_value,
  input  logic                trig_ext,
  uart_probe_sampler_if.slave rd,
  output logic [2:0]          state,
  output logic                triggered,
  output logic                done
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  // Terminal values of the write counter in FILL and POST. POST counts the
  // trigger sample itself, so it stops after DEPTH-PRE_TRIG samples.
  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE_TRIG - 1);
  localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(DEPTH - PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t cur, nxt;

  logic [PROBE_W-1:0] mem [DEPTH];
  logic [PROBE_W-1:0] rd_raw;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]   fill_cnt;
  logic               hit;
  logic               wr_en;
  logic               rd_fire;

  // An all-zero mask disables the pattern compare rather than matching
  // everything; only trig_ext can fire then.
  assign hit = ((|trig_mask) && ((probe & trig_mask) == (trig_value & trig_mask)))
             || trig_ext;

  // -------------------------------------------------------------------------
  // Next-state / control decode. arm outranks everything else.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    nxt     = cur;
    wr_en   = 1'b0;
    rd_fire = 1'b0;
    if (arm) begin
      nxt = (PRE_TRIG == 0) ? S_ARMED : S_FILL;
    end else begin
      case (cur)
        S_FILL: begin
          wr_en = 1'b1;
          if (fill_cnt == PRE_LAST) nxt = S_ARMED;
        end
        S_ARMED: begin
          wr_en = 1'b1;
          if (hit) nxt = (DEPTH - PRE_TRIG == 1) ? S_DONE : S_POST;
        end
        S_POST: begin
          wr_en = 1'b1;
          if (fill_cnt == POST_LAST) nxt = S_DONE;
        end
        S_DONE:  rd_fire = rd.rd_req;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) cur <= S_IDLE;
    else     cur <= nxt;
  end

  // -------------------------------------------------------------------------
  // Pointers, counters and status flags.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_cnt      <= '0;
      fill_cnt    <= '0;
      triggered   <= 1'b0;
      done        <= 1'b0;
      rd.rd_valid <= 1'b0;
      rd.rd_last  <= 1'b0;
    end else begin
      done        <= (nxt == S_DONE);
      rd.rd_valid <= rd_fire;
      // rd_cnt indexes the playback sample; DEPTH is a power of two, so the
      // DEPTH-th sample is the one where rd_cnt is all ones.
      rd.rd_last  <= rd_fire && (rd_cnt == '1);

      if (arm) begin
        wr_ptr    <= '0;
        fill_cnt  <= '0;
        rd_ptr    <= '0;
        rd_cnt    <= '0;
        triggered <= 1'b0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        case (cur)
          S_FILL: fill_cnt <= fill_cnt + 1'b1;
          S_ARMED: begin
            if (hit) begin
              // The trigger sample lands at wr_ptr; the oldest kept sample
              // sits PRE_TRIG slots behind it, which is where playback starts.
              rd_ptr    <= wr_ptr - PRE_OFS;
              rd_cnt    <= '0;
              fill_cnt  <= CNT_W'(1);
              triggered <= 1'b1;
            end
          end
          S_POST: fill_cnt <= fill_cnt + 1'b1;
          S_DONE: begin
            if (rd_fire) begin
              rd_ptr <= rd_ptr + 1'b1;
              rd_cnt <= rd_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Sample buffer: synchronous write, synchronous read (block-RAM friendly).
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the buffer and its read register carry no reset so they map onto
    // RAM; rd_data is masked by rd_valid to present zero outside playback.
    if (wr_en) mem[wr_ptr] <= probe;
    rd_raw <= mem[rd_ptr];
  end

  assign rd.rd_data = rd.rd_valid ? rd_raw : '0;
  assign state      = cur;

endmodule
